rotary_quadrature_decoder: RTL and testbench



---
 rtl/rotary_quadrature_decoder.sv | 69 ++++++
 tb/tb_rotary_quadrature_decoder.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rotary_quadrature_decoder.sv
// rotary_quadrature_decoder: cleans bouncy rotary-encoder contacts into a detent event level.
//   clk                 in   system clock, all logic on posedge
//   reset               in   synchronous active-high reset, clears all state
//   rota, rotb          in   raw asynchronous encoder contacts A and B
//   rotation_event      out  filtered detent level, rises once per detent
//   rotation_direction  out  1 = clockwise (A leads B), valid while rotation_event is high
//   step_pulse          out  one-cycle pulse on each rotation_event rising edge
//   position_count      out  wrapping detent count, +1 clockwise, -1 anticlockwise
module rotary_quadrature_decoder #(
   parameter int DEBOUNCE_CYCLES = 5000,
   parameter int CNT_W           = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rota,
   input  logic             rotb,
   output logic             rotation_event,
   output logic             rotation_direction,
   output logic             step_pulse,
   output logic [CNT_W-1:0] position_count
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] TERM = DW'(DEBOUNCE_CYCLES - 1);
   logic [1:0] s1, s2, db;
   logic       q1, q2, rise;
   always_ff @(posedge clk)
      if (reset) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= {rotb, rota};
         s2 <= s1;
      end
   // bit 0 carries contact A, bit 1 contact B; each debounces on its own
   for (genvar i = 0; i < 2; i++) begin : g_db
      logic [DW-1:0] cnt;
      logic          d;
      always_ff @(posedge clk)
         if (reset) begin
            cnt <= '0;
            d   <= 1'b0;
         end else if (s2[i] == d) cnt <= '0;
         else if (cnt == TERM) begin
            d   <= s2[i];
            cnt <= '0;
         end else cnt <= cnt + 1'b1;
      assign db[i] = d;
   end
   // q1 tracks the both-high/both-low detent phase, q2 which contact got there first
   assign rise = q1 & ~rotation_event;
   always_ff @(posedge clk)
      if (reset) begin
         q1                 <= 1'b0;
         q2                 <= 1'b0;
         rotation_event     <= 1'b0;
         rotation_direction <= 1'b0;
         step_pulse         <= 1'b0;
         position_count     <= '0;
      end else begin
         q1             <= (db == 2'b11) ? 1'b1 : (db == 2'b00) ? 1'b0 : q1;
         q2             <= (db == 2'b01) ? 1'b1 : (db == 2'b10) ? 1'b0 : q2;
         rotation_event <= q1;
         step_pulse     <= rise;
         if (rise) begin
            rotation_direction <= q2;
            position_count     <= q2 ? position_count + 1'b1 : position_count - 1'b1;
         end
      end
endmodule

// File: tb/tb_rotary_quadrature_decoder.sv
// tb_rotary_quadrature_decoder: vector table, corner sequences and random stimulus against a window-based model.
module tb_rotary_quadrature_decoder;
   localparam int DEB = 4;
   logic       clk = 1'b0, reset = 1'b1, rota = 1'b0, rotb = 1'b0;
   logic       rotation_event, rotation_direction, step_pulse;
   logic [7:0] position_count;
   int         total = 0, passed = 0, pulses = 0;
   rotary_quadrature_decoder #(.DEBOUNCE_CYCLES(DEB), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .rota(rota), .rotb(rotb),
      .rotation_event(rotation_event), .rotation_direction(rotation_direction),
      .step_pulse(step_pulse), .position_count(position_count)
   );
   always #5 clk = ~clk;
   // reference: pins delayed two samples, a contact flips once its last DEB samples all disagree with it
   bit m_s1[2], m_s2[2], m_db[2];
   bit hist[2][$];
   bit m_q1, m_q2, m_ev, m_dir, m_sp;
   int m_cnt;
   task automatic model_step();
      bit nd[2];
      bit all_diff;
      if (reset) begin
         for (int i = 0; i < 2; i++) begin
            m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; hist[i].delete();
         end
         {m_q1, m_q2, m_ev, m_dir, m_sp} = '0;
         m_cnt = 0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            hist[i].push_back(m_s2[i]);
            if (hist[i].size() > DEB) void'(hist[i].pop_front());
            all_diff = (hist[i].size() == DEB);
            foreach (hist[i][k]) if (hist[i][k] == m_db[i]) all_diff = 0;
            nd[i] = all_diff ? !m_db[i] : m_db[i];
         end
         m_sp = m_q1 && !m_ev;
         if (m_sp) begin
            m_dir = m_q2;
            m_cnt = (m_cnt + (m_q2 ? 1 : 255)) % 256;
         end
         m_ev = m_q1;
         if (m_db[0] && m_db[1]) m_q1 = 1;
         else if (!m_db[0] && !m_db[1]) m_q1 = 0;
         if (m_db[0] && !m_db[1]) m_q2 = 1;
         else if (!m_db[0] && m_db[1]) m_q2 = 0;
         m_db = nd;
         m_s2 = m_s1;
         m_s1[0] = rota;
         m_s1[1] = rotb;
      end
   endtask
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      if (step_pulse) pulses++;
      chk("model", {rotation_event, rotation_direction, step_pulse, position_count},
          {m_ev, m_dir, m_sp, m_cnt[7:0]});
   endtask
   task automatic hold(bit a, bit b, int n);
      rota = a;
      rotb = b;
      repeat (n) tick();
   endtask
   task automatic detent(bit cw, int n);
      if (cw) begin
         hold(1, 0, n); hold(1, 1, n); hold(0, 1, n); hold(0, 0, n);
      end else begin
         hold(0, 1, n); hold(1, 1, n); hold(1, 0, n); hold(0, 0, n);
      end
   endtask
   typedef struct {
      bit         a, b;
      int         n;
      bit         ev, dir;
      logic [7:0] cnt;
   } vec_t;
   vec_t tbl[12];
   initial begin
      tbl[0]  = '{1, 0, 20, 0, 0, 8'h00};
      tbl[1]  = '{1, 1, 20, 1, 1, 8'h01};
      tbl[2]  = '{0, 1, 20, 1, 1, 8'h01};
      tbl[3]  = '{0, 0, 20, 0, 1, 8'h01};
      tbl[4]  = '{0, 1, 20, 0, 1, 8'h01};
      tbl[5]  = '{1, 1, 20, 1, 0, 8'h00};
      tbl[6]  = '{1, 0, 20, 1, 0, 8'h00};
      tbl[7]  = '{0, 0, 20, 0, 0, 8'h00};
      tbl[8]  = '{0, 1, 20, 0, 0, 8'h00};
      tbl[9]  = '{1, 1, 20, 1, 0, 8'hFF};
      tbl[10] = '{1, 0, 20, 1, 0, 8'hFF};
      tbl[11] = '{0, 0, 20, 0, 0, 8'hFF};
      reset = 1;
      repeat (3) tick();
      reset = 0;
      chk("reset_outputs", {rotation_event, rotation_direction, step_pulse, position_count}, 11'h0);
      pulses = 0;
      repeat (50) tick();
      chk("idle_no_event", pulses, 0);
      foreach (tbl[r]) begin
         hold(tbl[r].a, tbl[r].b, tbl[r].n);
         chk($sformatf("vec%0d", r), {rotation_event, rotation_direction, step_pulse, position_count},
             {tbl[r].ev, tbl[r].dir, 1'b0, tbl[r].cnt});
      end
      hold(1, 0, 20);
      rotb = 1;
      repeat (DEB + 3) tick();
      chk("latency_before", rotation_event, 0);
      tick();
      chk("latency_event", {rotation_event, step_pulse, rotation_direction, position_count}, {3'b111, 8'h00});
      tick();
      chk("pulse_one_cycle", {rotation_event, step_pulse}, 2'b10);
      hold(0, 1, 20);
      hold(0, 0, 20);
      pulses = 0;
      rotb = 0;
      for (int k = 0; k < 30; k++) begin
         rota = (k % 4) != 3;
         tick();
      end
      chk("bounce_no_event", pulses, 0);
      hold(1, 0, 20);
      hold(1, 1, 20);
      hold(0, 1, 20);
      hold(0, 0, 20);
      chk("bounce_one_event", pulses, 1);
      chk("bounce_count", position_count, 8'h01);
      hold(1, 0, 20);
      rotb = 1;
      repeat (2) tick();
      reset = 1;
      tick();
      rota = 0;
      rotb = 0;
      repeat (2) tick();
      reset = 0;
      pulses = 0;
      repeat (20) tick();
      chk("midreset_no_event", pulses, 0);
      chk("midreset_outputs", {rotation_event, rotation_direction, step_pulse, position_count}, 11'h0);
      detent(1, 20);
      chk("after_reset_detent", {rotation_direction, position_count}, {1'b1, 8'h01});
      reset = 1;
      tick();
      reset = 0;
      pulses = 0;
      repeat (256) detent(1, 10);
      chk("wrap_pulses", pulses, 256);
      chk("wrap_count", position_count, 8'h00);
      for (int k = 0; k < 400; k++) begin
         reset = ($urandom_range(0, 99) == 0);
         rota  = 1'($urandom);
         rotb  = 1'($urandom);
         repeat ($urandom_range(1, 12)) tick();
      end
      reset = 0;
      for (int k = 0; k < 40; k++) detent(1'($urandom), $urandom_range(3, 12));
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
